// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - per-channel synchroniser, debouncer, edge pulses and hold-to-repeat strobe
module button_conditioner #(
    parameter int CHANNELS        = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 500,
    parameter int REPEAT_PERIOD   = 100
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [CHANNELS-1:0] i_in,
    input  logic                i_repeat_en,
    output logic [CHANNELS-1:0] o_level,
    output logic [CHANNELS-1:0] o_press,
    output logic [CHANNELS-1:0] o_release,
    output logic [CHANNELS-1:0] o_strobe
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int T_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int T_W   = $clog2(T_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [T_W-1:0]   T_DELAY  = T_W'(REPEAT_DELAY);
    localparam logic [T_W-1:0]   T_PERIOD = T_W'(REPEAT_PERIOD);
    localparam logic [T_W-1:0]   T_ONE    = T_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DELAY,
        ST_REPEAT
    } rpt_state_t;

    genvar g;
    generate
        for (g = 0; g < CHANNELS; g++) begin : g_ch
            logic [SYNC_STAGES-1:0] r_sync;
            logic [CNT_W-1:0]       r_cnt;
            logic                   r_level;
            logic                   r_press;
            logic                   r_release;
            logic                   r_strobe;
            rpt_state_t             r_state;
            rpt_state_t             w_state_nxt;
            logic [T_W-1:0]         r_t;
            logic [T_W-1:0]         w_t_nxt;
            logic                   w_s;
            logic                   w_settle;
            logic                   w_rise;
            logic                   w_fall;
            logic                   w_rpt;

            assign w_s      = r_sync[SYNC_STAGES-1];
            assign w_settle = (w_s != r_level) && (r_cnt == CNT_LAST);
            assign w_rise   = w_settle && w_s;
            assign w_fall   = w_settle && !w_s;

            always_ff @(posedge clock) begin
                if (reset) begin
                    r_sync    <= '0;
                    r_cnt     <= '0;
                    r_level   <= 1'b0;
                    r_press   <= 1'b0;
                    r_release <= 1'b0;
                    r_strobe  <= 1'b0;
                end else begin
                    r_sync <= {r_sync[SYNC_STAGES-2:0], i_in[g]};
                    if (w_s == r_level) begin
                        r_cnt <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_level <= w_s;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                    r_press   <= w_rise;
                    r_release <= w_fall;
                    r_strobe  <= w_rise | w_rpt;
                end
            end

            always_ff @(posedge clock) begin
                if (reset) begin
                    r_state <= ST_IDLE;
                    r_t     <= '0;
                end else begin
                    r_state <= w_state_nxt;
                    r_t     <= w_t_nxt;
                end
            end

            // t counts from 1 at the press cycle, so a match at t==N lands the strobe N cycles later
            always_comb begin
                w_state_nxt = r_state;
                w_t_nxt     = r_t;
                w_rpt       = 1'b0;
                if (w_fall || !i_repeat_en) begin
                    w_state_nxt = ST_IDLE;
                    w_t_nxt     = '0;
                end else begin
                    case (r_state)
                        ST_IDLE: begin
                            if (w_rise) begin
                                w_state_nxt = ST_DELAY;
                                w_t_nxt     = T_ONE;
                            end
                        end
                        ST_DELAY: begin
                            if (r_t == T_DELAY) begin
                                w_rpt       = 1'b1;
                                w_state_nxt = ST_REPEAT;
                                w_t_nxt     = T_ONE;
                            end else begin
                                w_t_nxt = r_t + T_ONE;
                            end
                        end
                        ST_REPEAT: begin
                            if (r_t == T_PERIOD) begin
                                w_rpt   = 1'b1;
                                w_t_nxt = T_ONE;
                            end else begin
                                w_t_nxt = r_t + T_ONE;
                            end
                        end
                        default: begin
                            w_state_nxt = ST_IDLE;
                            w_t_nxt     = '0;
                        end
                    endcase
                end
            end

            assign o_level[g]   = r_level;
            assign o_press[g]   = r_press;
            assign o_release[g] = r_release;
            assign o_strobe[g]  = r_strobe;
        end
    endgenerate
endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - directed and randomized checks of button_conditioner against a behavioural model
module tb_button_conditioner;
    localparam int CH  = 4;
    localparam int SY  = 2;
    localparam int DEB = 4;
    localparam int RD  = 5;
    localparam int RP  = 3;

    logic          clock = 1'b0;
    logic          reset;
    logic [CH-1:0] in_r;
    logic          repeat_en;
    logic [CH-1:0] o_level, o_press, o_release, o_strobe;

    button_conditioner #(
        .CHANNELS(CH), .SYNC_STAGES(SY), .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clock(clock), .reset(reset), .i_in(in_r), .i_repeat_en(repeat_en),
        .o_level(o_level), .o_press(o_press), .o_release(o_release), .o_strobe(o_strobe)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;
    int edge_n   = 0;

    bit m_pipe  [CH][SY];
    bit m_level [CH];
    int m_run   [CH];
    bit m_press [CH];
    bit m_rel   [CH];
    bit m_strobe[CH];
    bit m_armed [CH];
    int m_pe    [CH];

    int obs_press_edge[CH];
    int obs_rel_edge  [CH];
    int obs_press_cnt [CH];
    int obs_rel_cnt   [CH];
    int obs_strobe_cnt[CH];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    // Level follows the synchronised input once it has disagreed for DEB edges in a row;
    // strobes land at P, P+RD, P+RD+k*RP while the press stays armed.
    task automatic model_edge();
        for (int c = 0; c < CH; c++) begin
            if (reset) begin
                for (int k = 0; k < SY; k++) m_pipe[c][k] = 1'b0;
                m_level[c] = 0; m_run[c] = 0; m_press[c] = 0; m_rel[c] = 0;
                m_strobe[c] = 0; m_armed[c] = 0; m_pe[c] = 0;
            end else begin
                bit s;
                int d;
                s = m_pipe[c][SY-1];
                m_press[c] = 0;
                m_rel[c]   = 0;
                if (s != m_level[c]) begin
                    m_run[c]++;
                    if (m_run[c] == DEB) begin
                        m_level[c] = s;
                        m_run[c]   = 0;
                        if (s) m_press[c] = 1; else m_rel[c] = 1;
                    end
                end else begin
                    m_run[c] = 0;
                end
                if (m_press[c]) begin
                    m_pe[c]     = edge_n;
                    m_armed[c]  = repeat_en;
                    m_strobe[c] = 1;
                end else begin
                    if (!repeat_en || !m_level[c]) m_armed[c] = 0;
                    d = edge_n - m_pe[c];
                    m_strobe[c] = m_armed[c] && (d == RD || (d > RD && ((d - RD) % RP) == 0));
                end
                for (int k = SY - 1; k > 0; k--) m_pipe[c][k] = m_pipe[c][k-1];
                m_pipe[c][0] = in_r[c];
            end
        end
    endtask

    task automatic step();
        logic [CH-1:0] el, ep, er, es;
        @(posedge clock);
        edge_n++;
        model_edge();
        #1;
        for (int c = 0; c < CH; c++) begin
            el[c] = m_level[c]; ep[c] = m_press[c]; er[c] = m_rel[c]; es[c] = m_strobe[c];
        end
        check_val("level", 32'(o_level), 32'(el));
        check_val("press", 32'(o_press), 32'(ep));
        check_val("release", 32'(o_release), 32'(er));
        check_val("strobe", 32'(o_strobe), 32'(es));
        for (int c = 0; c < CH; c++) begin
            if (o_press[c] === 1'b1) begin obs_press_edge[c] = edge_n; obs_press_cnt[c]++; end
            if (o_release[c] === 1'b1) begin obs_rel_edge[c] = edge_n; obs_rel_cnt[c]++; end
            if (o_strobe[c] === 1'b1) obs_strobe_cnt[c]++;
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_obs();
        for (int c = 0; c < CH; c++) begin
            obs_press_edge[c] = -1; obs_rel_edge[c] = -1;
            obs_press_cnt[c] = 0; obs_rel_cnt[c] = 0; obs_strobe_cnt[c] = 0;
        end
    endtask

    task automatic wait_press(input int c, output int p_edge);
        bit found;
        found  = 0;
        p_edge = -1;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            if (o_press[c] === 1'b1) begin
                found  = 1;
                p_edge = edge_n;
            end
        end
        if (!found) check_val("press_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int e, p, rel_e;
        reset = 1'b1; in_r = '0; repeat_en = 1'b0;
        clear_obs();
        steps(3);
        check_val("reset_outputs", 32'({o_level, o_press, o_release, o_strobe}), 32'd0);
        reset = 1'b0;
        steps(5);

        // clean press and release on channel 0
        clear_obs();
        e = edge_n; in_r[0] = 1'b1;
        steps(20);
        check_val("t1_press_latency", 32'(obs_press_edge[0] - e), 32'(SY + DEB));
        check_val("t1_press_count", 32'(obs_press_cnt[0]), 32'd1);
        e = edge_n; in_r[0] = 1'b0;
        steps(12);
        check_val("t1_release_latency", 32'(obs_rel_edge[0] - e), 32'(SY + DEB));
        check_val("t1_release_count", 32'(obs_rel_cnt[0]), 32'd1);
        for (int c = 1; c < CH; c++) check_val("t1_other_quiet", 32'(obs_strobe_cnt[c] + obs_press_cnt[c]), 32'd0);

        // bounce 1,0,1,1,0 then steady 1
        clear_obs();
        in_r[0] = 1'b1; step(); in_r[0] = 1'b0; step(); in_r[0] = 1'b1; step();
        step(); in_r[0] = 1'b0; step();
        e = edge_n; in_r[0] = 1'b1;
        steps(12);
        check_val("t2_press_count", 32'(obs_press_cnt[0]), 32'd1);
        check_val("t2_press_latency", 32'(obs_press_edge[0] - e), 32'(SY + DEB));
        check_val("t2_no_release", 32'(obs_rel_cnt[0]), 32'd0);
        in_r[0] = 1'b0;
        steps(12);

        // auto-repeat
        clear_obs();
        repeat_en = 1'b1; in_r[0] = 1'b1;
        wait_press(0, p);
        check_val("t3_strobe_at_P", 32'(o_strobe[0]), 32'd1);
        for (int k = 1; k <= 15; k++) begin
            step();
            check_val("t3_strobe", 32'(o_strobe[0]),
                      32'((k == 5 || k == 8 || k == 11 || k == 14) ? 1 : 0));
        end
        in_r[0] = 1'b0;
        for (int i = 0; i < 10 && obs_rel_cnt[0] == 0; i++) step();
        check_val("t3_released", 32'(obs_rel_cnt[0]), 32'd1);
        e = obs_strobe_cnt[0];
        steps(10);
        check_val("t3_no_strobe_after_release", 32'(obs_strobe_cnt[0] - e), 32'd0);

        // repeat_en dropped then raised while held
        clear_obs();
        in_r[0] = 1'b1;
        wait_press(0, p);
        steps(5);
        check_val("t4_strobe_P5", 32'(o_strobe[0]), 32'd1);
        e = obs_strobe_cnt[0];
        repeat_en = 1'b0; steps(3);
        repeat_en = 1'b1; steps(15);
        check_val("t4_no_more_strobes", 32'(obs_strobe_cnt[0] - e), 32'd0);
        in_r[0] = 1'b0;
        steps(12);

        // reset mid-repeat with the button held
        clear_obs();
        in_r[0] = 1'b1;
        wait_press(0, p);
        steps(6);
        reset = 1'b1; step();
        check_val("t5_reset_outputs", 32'({o_level, o_press, o_release, o_strobe}), 32'd0);
        reset = 1'b0; rel_e = edge_n;
        wait_press(0, p);
        check_val("t5_press_after_reset", 32'(p - rel_e), 32'(SY + DEB));
        in_r[0] = 1'b0;
        steps(12);

        // channel independence
        clear_obs();
        repeat_en = 1'b0;
        e = edge_n; in_r[0] = 1'b1; in_r[3] = 1'b1;
        steps(2); in_r[1] = 1'b1;
        steps(12);
        check_val("t6_ch0_latency", 32'(obs_press_edge[0] - e), 32'(SY + DEB));
        check_val("t6_ch3_latency", 32'(obs_press_edge[3] - e), 32'(SY + DEB));
        check_val("t6_ch1_latency", 32'(obs_press_edge[1] - e), 32'(SY + DEB + 2));
        check_val("t6_ch2_quiet", 32'(obs_press_cnt[2] + obs_strobe_cnt[2]), 32'd0);
        in_r = '0;
        steps(12);

        // randomized: held/bouncy inputs, enable toggles, occasional reset
        for (int i = 0; i < 2000; i++) begin
            for (int c = 0; c < CH; c++)
                if ($urandom_range(7, 0) == 0) in_r[c] = ~in_r[c];
            if ($urandom_range(63, 0) == 0) repeat_en = ~repeat_en;
            reset = ($urandom_range(499, 0) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/button_conditioner.md
# button_conditioner

Multi-channel front end for the game's push-button and switch inputs. Each channel synchronises its raw asynchronous input, debounces it, and produces one-cycle press and release pulses. It also produces an optional hold-to-repeat strobe. It sits between the board pins and the game control FSMs (frog movement, start/pause) and generalises the existing single-channel rising-edge detector.

## Interface
- CHANNELS, 4: number of independent input channels (≥1).
- SYNC_STAGES, 2: synchroniser flops per channel (≥2).
- DEBOUNCE_CYCLES, 16: consecutive cycles a synchronised value must differ from `level` before `level` follows it (≥1).
- REPEAT_DELAY, 500: cycles from press to the first auto-repeat strobe (≥2).
- REPEAT_PERIOD, 100: cycles between subsequent auto-repeat strobes (≥2).
- clock, input, 1: system clock; all logic on posedge.
- reset, input, 1: synchronous, active-high.
- in, input, CHANNELS: raw asynchronous inputs, active-high.
- repeat_en, input, 1: global auto-repeat enable, sampled every cycle.
- level, output, CHANNELS: debounced, registered level.
- press, output, CHANNELS: one-cycle pulse when `level` goes 0→1.
- release, output, CHANNELS: one-cycle pulse when `level` goes 1→0.
- strobe, output, CHANNELS: `press` pulses plus auto-repeat pulses.

## Operation
Channels are fully independent and identical. Describe channel i.

- **Synchroniser.** A chain of SYNC_STAGES flops captures `in[i]`. Its last stage is `s`.
- **Debounce counter `cnt`.** Width is clog2(DEBOUNCE_CYCLES+1).
  - If `s == level`: `cnt <= 0`.
  - Else, if `cnt == DEBOUNCE_CYCLES-1`: `level <= s` and `cnt <= 0`.
  - Else: `cnt <= cnt + 1`.
  - Any glitch shorter than DEBOUNCE_CYCLES synchronised cycles restarts the count and never changes `level`.
- **Edge pulses.** `press` and `release` are registered and update on the same edge as `level`. So `press` is high exactly in the first cycle `level` reads 1, and `release` is high exactly in the first cycle `level` reads 0.
- **Repeat FSM.** One per channel, with states IDLE, DELAY and REPEAT, plus a timer `t`. The width of `t` is clog2(max(REPEAT_DELAY, REPEAT_PERIOD)+1).
  - IDLE: on the edge that raises `level`, if `repeat_en` is high, go to DELAY with `t <= 1`.
  - DELAY: `t` increments each cycle. When `t == REPEAT_DELAY-1`, assert `rpt` next cycle, go to REPEAT and set `t <= 1`.
  - REPEAT: `t` increments. When `t == REPEAT_PERIOD-1`, assert `rpt` next cycle and set `t <= 1`.
  - From any state: if `level` is going to 0, or `repeat_en` is low, go to IDLE with `t <= 0` and no `rpt`. A release has priority over a coincident repeat.
- **Strobe.** `strobe = press | rpt`, registered. `rpt` and `press` are never high in the same cycle.
- **Effect of `repeat_en` low.** `strobe` equals `press`. Raising `repeat_en` while a channel is held does not start repeats until the next press.

## Timing
- **Reset.** Every flop clears: synchroniser stages, `cnt`, `level`, `press`, `release`, `strobe`, `t`, and FSM = IDLE. All outputs are 0 in the cycle after a reset edge.
- **Reset mid-operation.** Reset mid-debounce or mid-repeat aborts with no pulse. A button held through reset produces `press` SYNC_STAGES+DEBOUNCE_CYCLES cycles after reset deasserts.
- **Press latency.** `in` rises and then stays stable before edge 0. `level` and `press` become high after edge SYNC_STAGES+DEBOUNCE_CYCLES. Release latency is identical.
- **Repeat timing.** With P = the press cycle, `strobe` is high in cycles P, P+REPEAT_DELAY, P+REPEAT_DELAY+k·REPEAT_PERIOD (k≥1), for as long as `level` and `repeat_en` stay 1.
- **Pulse width.** Each pulse is exactly one cycle. A bounce that returns to the current `level` produces no pulse.
- **DEBOUNCE_CYCLES=1.** `level` is `s` delayed by one cycle, which is the legacy edge-detector behaviour.

## Test plan
1. Reset, then a clean press. Params: SYNC=2, DEB=4; `in[0]` rises at cycle 10 and holds 20 cycles, `repeat_en=0`. Required: `level[0]` and `press[0]` rise after edge 16; `press[0]` is high for one cycle; `release[0]` is high for one cycle 6 cycles after `in` falls. Other channels stay 0.
2. Bounce rejection. DEB=4; `in` toggles 1,0,1,1,0 per cycle, then stays 1. Required: no pulse during the bounce; one `press` 6 cycles after the final rise.
3. Auto-repeat. DELAY=5, PERIOD=3, `repeat_en=1`; hold 15 cycles after press cycle P. Required: `strobe` high at P, P+5, P+8, P+11, P+14 only; no `strobe` after `release`.
4. Repeat_en toggle. Drop `repeat_en` at P+6, raise it at P+9, still held. Required: no further `strobe` until the next press.
5. Reset mid-repeat. Assert reset at P+7 for 1 cycle, `in` held. Required: outputs are 0 the cycle after; `press` recurs at reset release + SYNC+DEB.
6. Channel independence. Press ch0 and ch3 simultaneously and ch1 2 cycles later. Required: per-channel pulses at their own latencies; no cross-channel interaction.
